// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin arbiter sharing one iterative sqrt unit among NREQ requesters
//
// Optional feature: define SQRT_ARB_CACHE_EN to add a one-entry result cache
// (a grant whose radicand matches the cached one is answered without using the sqrt unit).
//
// Ports:
//   clk_in, rst_in   clock (posedge) and synchronous active-high reset
//   req_valid_in     per-requester request, held with its operand until accepted
//   req_a_in         packed radicands, requester i at [i*A_W +: A_W]
//   req_ready_out    one-hot combinational accept in IDLE
//   rsp_valid_out    one-hot one-cycle result pulse to the accepted requester
//   rsp_y_out        root, held until the next response
//   busy_out         high whenever the arbiter is not idle
//   sq_start_out     one-cycle start pulse to the sqrt unit
//   sq_a_out         radicand to the sqrt unit, latched at accept
//   sq_busy_in       sqrt unit busy
//   sq_y_in          sqrt unit result, valid once busy falls
module sqrt_arbiter #(
  parameter int NREQ = 4,
  parameter int A_W  = 8,
  parameter int Y_W  = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NREQ-1:0]     req_valid_in,
  input  logic [NREQ*A_W-1:0] req_a_in,
  output logic [NREQ-1:0]     req_ready_out,
  output logic [NREQ-1:0]     rsp_valid_out,
  output logic [Y_W-1:0]      rsp_y_out,
  output logic                busy_out,
  output logic                sq_start_out,
  output logic [A_W-1:0]      sq_a_out,
  input  logic                sq_busy_in,
  input  logic [Y_W-1:0]      sq_y_in
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   id;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic            found;
  logic            hit;
  logic [A_W-1:0]  sel_a;
  logic [A_W-1:0]  a_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_in[g*A_W +: A_W];
  end

  // First valid requester scanning ptr, ptr+1, ... with wraparound.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid_in[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign sel_a = a_arr[win];

`ifdef SQRT_ARB_CACHE_EN
  logic           cache_vld;
  logic [A_W-1:0] cache_a;
  logic [Y_W-1:0] cache_y;

  assign hit = cache_vld && (sel_a == cache_a);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    req_ready_out = '0;
    rsp_valid_out = '0;
    sq_start_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          req_ready_out[win] = 1'b1;
          state_nx           = hit ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        sq_start_out = 1'b1;
        state_nx     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (sq_busy_in) state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!sq_busy_in) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid_out[id] = 1'b1;
        state_nx          = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // No accept may be signalled while reset is being applied.
    if (rst_in) req_ready_out = '0;
  end

  assign busy_out = (state != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id        <= '0;
      sq_a_out  <= '0;
      rsp_y_out <= '0;
`ifdef SQRT_ARB_CACHE_EN
      cache_vld <= 1'b0;
      cache_a   <= '0;
      cache_y   <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == S_IDLE && found) begin
        ptr      <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        id       <= win;
        sq_a_out <= sel_a;
`ifdef SQRT_ARB_CACHE_EN
        if (hit) rsp_y_out <= cache_y;
`endif
      end
      if (state == S_WAIT_DONE && !sq_busy_in) begin
        rsp_y_out <= sq_y_in;
`ifdef SQRT_ARB_CACHE_EN
        cache_vld <= 1'b1;
        cache_a   <= sq_a_out;
        cache_y   <= sq_y_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - scoreboard testbench for sqrt_arbiter with a behavioural sqrt unit
module tb_sqrt_arbiter;

  localparam int NREQ = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;
  logic [3:0]       rsp_y;
  logic             busy;
  logic             sq_start;
  logic [7:0]       sq_a;
  logic             sq_busy = 1'b0;
  logic [3:0]       sq_y = '0;

  sqrt_arbiter #(.NREQ(NREQ), .A_W(8), .Y_W(4)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid_in  (req_valid),
    .req_a_in      (req_a),
    .req_ready_out (req_ready),
    .rsp_valid_out (rsp_valid),
    .rsp_y_out     (rsp_y),
    .busy_out      (busy),
    .sq_start_out  (sq_start),
    .sq_a_out      (sq_a),
    .sq_busy_in    (sq_busy),
    .sq_y_in       (sq_y)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(int a);
    int r = 0;
    for (int k = 0; k < 16; k++) if (k * k <= a) r = k;
    return r;
  endfunction

  // Behavioural sqrt unit: busy for five cycles after start, garbage result until done.
  int         sq_cnt = 0;
  logic [7:0] sq_la = '0;
  always @(posedge clk) begin
    if (rst) begin
      sq_cnt  <= 0;
      sq_busy <= 1'b0;
      sq_y    <= '0;
    end else if (sq_start) begin
      sq_cnt  <= 5;
      sq_busy <= 1'b1;
      sq_la   <= sq_a;
      sq_y    <= 4'($urandom);
    end else if (sq_cnt > 1) begin
      sq_cnt  <= sq_cnt - 1;
      sq_y    <= 4'($urandom);
    end else if (sq_cnt == 1) begin
      sq_cnt  <= 0;
      sq_busy <= 1'b0;
      sq_y    <= 4'(isqrt(int'(sq_la)));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  typedef struct {
    int id;
    int y;
    int cyc;
    int a;
    bit hit;
  } exp_t;

  exp_t q[$];
  int   ptr_m = 0;
  int   free_at = 0;
  int   exp_start_cyc = -1;
  int   exp_start_a = 0;
  int   grants = 0;
  bit   post_rst = 1'b0;
  bit   cache_vld_m = 1'b0;
  int   cache_a_m = 0;
  int   cache_y_m = 0;
  logic [NREQ-1:0] acc_mask = '0;

  // Reference model and monitor, sampled on the falling edge.
  always @(negedge clk) begin
    int     w;
    int     a;
    bit     hit;
    bit     busy_exp;
    exp_t   e;
    logic [NREQ-1:0] exp_ready;
    if (rst) begin
      chk("ready_in_reset", int'(req_ready), 0);
      q.delete();
      ptr_m         = 0;
      free_at       = cyc + 1;
      exp_start_cyc = -1;
      cache_vld_m   = 1'b0;
      post_rst      = 1'b1;
      acc_mask      = '0;
    end else begin
      if (post_rst) begin
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_y", int'(rsp_y), 0);
        chk("rst_sq_start", int'(sq_start), 0);
        chk("rst_sq_a", int'(sq_a), 0);
        post_rst = 1'b0;
      end
      busy_exp  = (cyc < free_at);
      exp_ready = '0;
      if (!busy_exp && req_valid != 0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
        exp_ready[w] = 1'b1;
        ptr_m = (w + 1) % NREQ;
        a = int'(req_a[w*8 +: 8]);
        grants++;
`ifdef SQRT_ARB_CACHE_EN
        hit = cache_vld_m && (a == cache_a_m);
`else
        hit = 1'b0;
`endif
        if (hit) begin
          q.push_back('{id: w, y: cache_y_m, cyc: cyc + 1, a: a, hit: 1'b1});
          free_at = cyc + 2;
        end else begin
          q.push_back('{id: w, y: isqrt(a), cyc: cyc + 8, a: a, hit: 1'b0});
          free_at       = cyc + 9;
          exp_start_cyc = cyc + 1;
          exp_start_a   = a;
        end
      end
      chk("req_ready", int'(req_ready), int'(exp_ready));
      acc_mask = req_ready & req_valid;
      chk("busy", int'(busy), int'(busy_exp));
      chk("sq_start", int'(sq_start), int'(cyc == exp_start_cyc));
      if (cyc == exp_start_cyc) chk("sq_a", int'(sq_a), exp_start_a);
      if (rsp_valid != 0) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", int'(rsp_valid), 0);
        end else begin
          e = q.pop_front();
          chk("rsp_id", int'(rsp_valid), 1 << e.id);
          chk("rsp_y", int'(rsp_y), e.y);
          chk("rsp_cycle", cyc, e.cyc);
          if (!e.hit) begin
            cache_vld_m = 1'b1;
            cache_a_m   = e.a;
            cache_y_m   = e.y;
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        chk("rsp_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  bit         v [NREQ];
  bit         sticky [NREQ];
  logic [7:0] av [NREQ];

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]     = v[i];
      req_a[i*8 +: 8]  = av[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc_mask[i] && !sticky[i]) v[i] = 1'b0;
    apply();
  endtask

  task automatic set_req(int i, int a);
    v[i]  = 1'b1;
    av[i] = 8'(a);
    apply();
  endtask

  task automatic wait_drain(int max);
    int  n = 0;
    bit  pend = 1'b1;
    while (pend && n < max) begin
      step();
      n++;
      pend = (q.size() != 0) || (cyc < free_at);
      for (int i = 0; i < NREQ; i++) if (v[i]) pend = 1'b1;
    end
    chk("drain_timeout", int'(pend), 0);
  endtask

  task automatic wait_grant(int g0, int max);
    int n = 0;
    while (grants == g0 && n < max) begin
      step();
      n++;
    end
    chk("grant_timeout", int'(grants == g0), 0);
  endtask

  initial begin
    int g0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0;
      sticky[i] = 1'b0;
      av[i] = '0;
    end
    rst = 1'b1;
    apply();
    repeat (3) step();
    rst = 1'b0;

    // Single request, a=144.
    set_req(0, 144);
    wait_drain(40);

    // All four at once.
    set_req(0, 0);
    set_req(1, 1);
    set_req(2, 255);
    set_req(3, 100);
    wait_drain(60);

    // Two requesters held continuously.
    sticky[1] = 1'b1;
    sticky[3] = 1'b1;
    set_req(1, 64);
    set_req(3, 225);
    repeat (40) step();
    sticky[1] = 1'b0;
    sticky[3] = 1'b0;
    v[1] = 1'b0;
    v[3] = 1'b0;
    apply();
    wait_drain(40);

    // Reset while waiting for the sqrt unit.
    g0 = grants;
    set_req(0, 200);
    wait_grant(g0, 20);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    apply();
    set_req(2, 81);
    wait_drain(40);

    // Same radicand twice.
    set_req(2, 49);
    wait_drain(40);
    set_req(2, 49);
    wait_drain(40);

    // Short-lived request while busy is withdrawn.
    g0 = grants;
    set_req(1, 30);
    wait_grant(g0, 20);
    repeat (2) step();
    set_req(3, 170);
    step();
    v[3] = 1'b0;
    apply();
    wait_drain(40);

    // Randomized traffic with withdrawals and repeated operands.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1'b1;
          if ($urandom_range(0, 1) == 0) av[i] = 8'($urandom);
        end else if (v[i] && $urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      apply();
      step();
    end
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    apply();
    wait_drain(60);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
